// File: rtl/ddr_pkg.sv
// Shared definitions for the serializer/deserializer link: FSM encoding,
// default training word and a saturating counter helper.
package ddr_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   // Lane 0 (0x96) is sent first and appears in no other lane.
   localparam logic [31:0] DEFAULT_TRAIN_PATTERN = 32'hA53C0F96;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/deserializer_if.sv
// Lane-stream and frame-output bundle of the deserializer. The master side
// drives the lane stream; the slave side (the deserializer) returns frames.
interface deserializer_if #(
   parameter int D = 8,
   parameter int S = 4
);

   logic [D-1:0]   data_in;
   logic           realign;
   logic [D*S-1:0] data_out;
   logic           data_valid;
   logic           aligned;
   logic [7:0]     slip_count;

   modport master (
      output data_in, realign,
      input  data_out, data_valid, aligned, slip_count
   );

   modport slave (
      input  data_in, realign,
      output data_out, data_valid, aligned, slip_count
   );

endinterface

// File: rtl/deserializer_frame_assembler.sv
// Lane counter and partial-frame storage; presents the completed frame
// combinationally on the cycle its last lane arrives.
module frame_assembler #(
   parameter int D = 8,
   parameter int S = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           load_lane0,
   input  logic           advance,
   input  logic [D-1:0]   data_in,
   output logic           frame_done,
   output logic [D*S-1:0] frame
);

   localparam int              LW        = $clog2(S);
   localparam logic [LW-1:0]   LANE_LAST = LW'(S - 1);

   // The last lane is never stored: it goes straight onto the frame bus.
   logic [LW-1:0]        lane_q, lane_d;
   logic [(S-1)*D-1:0]   frame_sr_q, frame_sr_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      lane_d     = lane_q;
      frame_sr_d = frame_sr_q;
      if (clear) begin
         lane_d = '0;
      end else if (load_lane0) begin
         frame_sr_d[D-1:0] = data_in;
         lane_d            = LW'(1);
      end else if (advance) begin
         for (int k = 0; k < S - 1; k++) begin
            if (lane_q == LW'(k)) frame_sr_d[k*D +: D] = data_in;
         end
         lane_d = lane_q + 1'b1;
      end
   end

   assign frame_done = advance && (lane_q == LANE_LAST);
   assign frame      = {data_in, frame_sr_q};

   // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      // NOTE: the lane storage shares the counter's reset branch; leaving it unreset in this block would turn reset into a load-enable on those bits.
      if (reset) begin
         lane_q     <= '0;
         frame_sr_q <= '0;
      end else begin
         lane_q     <= lane_d;
         frame_sr_q <= frame_sr_d;
      end
   end

endmodule

// File: rtl/deserializer.sv
// Lane-to-frame deserializer: hunts for the training word, locks after
// LOCK_FRAMES clean training frames, then emits one frame every S cycles.
module deserializer
   import ddr_pkg::*;
#(
   parameter int               D             = 8,
   parameter int               S             = 4,
   parameter logic [D*S-1:0]   TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
   parameter int               LOCK_FRAMES   = 2
) (
   input logic           high_speed_clock,
   input logic           reset,
   deserializer_if.slave bus
);

   localparam int            MW         = $clog2(LOCK_FRAMES) + 1;
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_FRAMES - 1);

   state_e         state_q, state_d;
   logic [MW-1:0]  match_q, match_d;
   logic [D*S-1:0] data_out_q, data_out_d;
   logic           data_valid_q, data_valid_d;
   logic           aligned_q, aligned_d;
   logic [7:0]     slip_count_q, slip_count_d;

   logic           load_lane0;
   logic           advance;
   logic           frame_done;
   logic [D*S-1:0] frame;

   // realign masks both assembler controls so it wins over a completing frame.
   assign load_lane0 = (state_q == HUNT) && !bus.realign
                       && (bus.data_in == TRAIN_PATTERN[D-1:0]);
   assign advance    = (state_q != HUNT) && !bus.realign;

   frame_assembler #(
      .D (D),
      .S (S)
   ) u_frame_assembler (
      .clk        (high_speed_clock),
      .reset      (reset),
      .clear      (bus.realign),
      .load_lane0 (load_lane0),
      .advance    (advance),
      .data_in    (bus.data_in),
      .frame_done (frame_done),
      .frame      (frame)
   );

   always_comb begin
      state_d      = state_q;
      match_d      = match_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      aligned_d    = aligned_q;
      slip_count_d = slip_count_q;
      if (bus.realign) begin
         state_d   = HUNT;
         match_d   = '0;
         aligned_d = 1'b0;
      end else begin
         case (state_q)
            HUNT: begin
               if (load_lane0) begin
                  state_d = CHECK;
                  match_d = '0;
               end
            end
            CHECK: begin
               if (frame_done) begin
                  if (frame == TRAIN_PATTERN) begin
                     if (match_q == MATCH_LAST) begin
                        state_d   = LOCKED;
                        aligned_d = 1'b1;
                     end else begin
                        match_d = match_q + 1'b1;
                     end
                  end else begin
                     state_d      = HUNT;
                     slip_count_d = sat_inc8(slip_count_q);
                  end
               end
            end
            LOCKED: begin
               // Payload is passed through unchecked; lock is only left via realign or reset.
               if (frame_done) begin
                  data_out_d   = frame;
                  data_valid_d = 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge high_speed_clock) begin
      if (reset) begin
         state_q      <= HUNT;
         match_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         aligned_q    <= 1'b0;
         slip_count_q <= '0;
      end else begin
         state_q      <= state_d;
         match_q      <= match_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         aligned_q    <= aligned_d;
         slip_count_q <= slip_count_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.aligned    = aligned_q;
   assign bus.slip_count = slip_count_q;

endmodule
